scr1_brkm_bp_ctrl: RTL and testbench
====================================

Name: scr1_brkm_bp_ctrl

Overview:
Breakpoint controller sitting directly downstream of the per-channel BRKM matchers. It qualifies raw per-channel match results with channel enable and chaining configuration, and keeps sticky per-channel hit status for the CSR file. It arbitrates simultaneous hits and issues one breakpoint event at a time to the hart pipeline over a req/ack handshake. It tracks debug-halt state until resume.

Parameters:
BRKM_BP_NUM, 2, number of breakpoint channels (1..8); one matcher instance feeds each channel.
BRKM_BP_ID_W, 3, width of the channel index output; must satisfy 2**BRKM_BP_ID_W >= BRKM_BP_NUM.

Ports:
clk  in  1  core clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
match  in  BRKM_BP_NUM  per-channel match outputs of the matchers (already valid-qualified)
cfg_en  in  BRKM_BP_NUM  per-channel enable (bpcontrol.EN)
cfg_chain  in  BRKM_BP_NUM  channel i chained with i+1; bit BRKM_BP_NUM-1 ignored
cfg_action  in  BRKM_BP_NUM  0 = raise breakpoint exception, 1 = enter debug halt
hit_clr  in  BRKM_BP_NUM  CSR write-1-to-clear of sticky hit bits
pipe_flush  in  1  pipeline flush; withdraws an unacknowledged request
dbg_resume  in  1  debugger resume pulse; leaves HALTED
bp_req  out  1  breakpoint event request to hart
bp_ack  in  1  hart accepts event this cycle (meaningful only when bp_req=1)
bp_id  out  BRKM_BP_ID_W  index of the channel carried by bp_req
bp_action  out  1  action of the requested event
hit_status  out  BRKM_BP_NUM  sticky per-channel hit bits (bpcontrol.HIT)
hit_ovf  out  1  sticky: a qualified hit arrived while not IDLE; cleared when any hit_clr bit is set
halted  out  1  controller in HALTED state

Behaviour:
- Reset: bp_req=0, bp_id=0, bp_action=0, hit_status=0, hit_ovf=0, halted=0, FSM=IDLE.
- Qualified hit (combinational), per channel i:
  - q[i] = cfg_en[i] & match[i].
  - If cfg_chain[i]=1 and i<BRKM_BP_NUM-1: q[i] = cfg_en[i] & cfg_en[i+1] & match[i] & match[i+1], and q[i+1] is forced 0 for that cycle.
  - Chaining does not cascade: if channel i+1 is chained into i, its own cfg_chain bit is still evaluated for i+1/i+2 only when not forced.
- hit_status[i]:
  - Set next cycle when q[i]=1, in any FSM state.
  - Cleared by hit_clr[i].
  - If set and clear occur in the same cycle, set wins.
  - For a chained pair, only the lower index is set.
- Arbitration: lowest index with q=1 wins.
- FSM states:
  - IDLE: bp_req=0. If any q=1, latch bp_id (winning index) and bp_action=cfg_action[winner], then go to REQ next cycle. Latency from match to bp_req is 1 cycle.
  - REQ: bp_req=1. bp_id and bp_action are held stable until they leave REQ, irrespective of cfg changes.
    - bp_ack=1: go to HALTED if bp_action=1, else IDLE.
    - pipe_flush=1 without bp_ack: go to IDLE, request withdrawn (hit_status kept).
    - bp_ack and pipe_flush together: ack wins.
  - HALTED: halted=1, bp_req=0. dbg_resume=1 moves to IDLE next cycle. A q=1 in the same cycle as dbg_resume does not start a request (it sets hit_ovf).
- hit_ovf:
  - Set when any q=1 while FSM != IDLE.
  - Cleared when any hit_clr bit is 1 and no set condition occurs that cycle.
  - Set wins over clear.
- In IDLE, a q=1 in the same cycle as pipe_flush still starts a request (flush affects only REQ).
- dbg_resume outside HALTED is ignored.
- Asynchronous reset mid-REQ or mid-HALTED drops bp_req/halted immediately.
- bp_ack while bp_req=0 is ignored.

Test Plan:
- Single hit: N=2, cfg_en=01, cfg_action=00, match=01 for 1 cycle -> next cycle bp_req=1, bp_id=0, bp_action=0, hit_status=01; bp_ack one cycle later -> bp_req=0, FSM IDLE.
- Priority and overflow: match=11 (both enabled) -> bp_id=0, hit_status=11; match=10 while REQ -> hit_ovf=1, no second request after ack; hit_clr=01 -> hit_status=10, hit_ovf=0.
- Chaining: cfg_chain=01, cfg_en=11; match=01 -> no event; match=11 -> bp_id=0, hit_status=01 (bit1 stays 0).
- Debug halt: cfg_action=01, hit ch0, ack -> halted=1; further match -> hit_ovf=1, bp_req stays 0; dbg_resume -> halted=0 next cycle, IDLE.
- Flush/ack races: in REQ assert pipe_flush alone -> bp_req=0 next cycle, hit_status retained; repeat with pipe_flush and bp_ack together -> treated as ack (HALTED when action=1); hit_clr and new hit on the same bit -> bit remains 1.
- Reset mid-REQ: drive rst_n low asynchronously between edges -> bp_req, halted, hit_status, hit_ovf all 0 immediately; after release no event until a new match.

Source files
------------

// File: rtl/scr1_brkm_bp_ctrl.sv
// scr1_brkm_bp_ctrl: qualifies matcher hits, keeps sticky hit status, arbitrates and issues breakpoint events over req/ack
module scr1_brkm_bp_ctrl #(
    parameter int BRKM_BP_NUM  = 2,
    parameter int BRKM_BP_ID_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BRKM_BP_NUM-1:0]  match,
    input  logic [BRKM_BP_NUM-1:0]  cfg_en,
    input  logic [BRKM_BP_NUM-1:0]  cfg_chain,
    input  logic [BRKM_BP_NUM-1:0]  cfg_action,
    input  logic [BRKM_BP_NUM-1:0]  hit_clr,
    input  logic                    pipe_flush,
    input  logic                    dbg_resume,
    output logic                    bp_req,
    input  logic                    bp_ack,
    output logic [BRKM_BP_ID_W-1:0] bp_id,
    output logic                    bp_action,
    output logic [BRKM_BP_NUM-1:0]  hit_status,
    output logic                    hit_ovf,
    output logic                    halted
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HALT = 2'd2} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [BRKM_BP_NUM:0]    w_en_x;
    logic [BRKM_BP_NUM:0]    w_m_x;
    logic [BRKM_BP_NUM-1:0]  w_q;
    logic [BRKM_BP_NUM-1:0]  r_hit;
    logic [BRKM_BP_ID_W-1:0] w_id;
    logic [BRKM_BP_ID_W-1:0] r_id;
    logic                    w_fwd;
    logic                    w_any;
    logic                    w_act;
    logic                    r_act;
    logic                    r_ovf;

    // A zero pad bit lets channel i look at i+1 without a range special case for the top channel
    assign w_en_x = {1'b0, cfg_en};
    assign w_m_x  = {1'b0, match};
    assign w_any  = |w_q;

    // Qualify hits; w_fwd marks a channel absorbed by the chain of the one below, whose own chain bit is then ignored
    always_comb begin
        w_fwd = 1'b0;
        w_q   = '0;
        for (int i = 0; i < BRKM_BP_NUM; i++) begin
            w_q[i] = ~w_fwd & (((i < BRKM_BP_NUM - 1) && cfg_chain[i]) ?
                               (w_en_x[i] & w_en_x[i+1] & w_m_x[i] & w_m_x[i+1]) :
                               (w_en_x[i] & w_m_x[i]));
            w_fwd  = ~w_fwd & (i < BRKM_BP_NUM - 1) & cfg_chain[i];
        end
    end

    // Lowest qualified channel wins; scanning downward leaves the lowest index last
    always_comb begin
        w_id  = '0;
        w_act = 1'b0;
        for (int i = BRKM_BP_NUM - 1; i >= 0; i--) begin
            if (w_q[i]) begin
                w_id  = BRKM_BP_ID_W'(i);
                w_act = cfg_action[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state: ack beats flush in REQ, resume only matters in HALT
    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_any ? S_REQ : S_IDLE) :
                 (r_state == S_REQ)  ? (bp_ack ? (r_act ? S_HALT : S_IDLE) : (pipe_flush ? S_IDLE : S_REQ)) :
                 (r_state == S_HALT) ? (dbg_resume ? S_IDLE : S_HALT) :
                 S_IDLE;
    end

    // Outputs decoded from state and the latched event
    always_comb begin
        bp_req     = (r_state == S_REQ);
        halted     = (r_state == S_HALT);
        bp_id      = r_id;
        bp_action  = r_act;
        hit_status = r_hit;
        hit_ovf    = r_ovf;
    end

    // Event latch (only when leaving IDLE) and sticky status, where set always beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id  <= '0;
            r_act <= 1'b0;
            r_hit <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_id  <= w_id;
                r_act <= w_act;
            end
            r_hit <= w_q | (r_hit & ~hit_clr);
            r_ovf <= (w_any && r_state != S_IDLE) | (r_ovf & ~(|hit_clr));
        end
    end
endmodule

// File: tb/tb_scr1_brkm_bp_ctrl.sv
// tb_scr1_brkm_bp_ctrl: table-driven vectors through a scoreboard queue, plus asynchronous reset sequences
module tb_scr1_brkm_bp_ctrl;
    localparam int N = 2;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] match, cfg_en, cfg_chain, cfg_action, hit_clr;
    logic         pipe_flush, dbg_resume, bp_ack;
    logic         bp_req, bp_action, hit_ovf, halted;
    logic [W-1:0] bp_id;
    logic [N-1:0] hit_status;

    scr1_brkm_bp_ctrl #(.BRKM_BP_NUM(N), .BRKM_BP_ID_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .match(match), .cfg_en(cfg_en), .cfg_chain(cfg_chain),
        .cfg_action(cfg_action), .hit_clr(hit_clr), .pipe_flush(pipe_flush), .dbg_resume(dbg_resume),
        .bp_req(bp_req), .bp_ack(bp_ack), .bp_id(bp_id), .bp_action(bp_action),
        .hit_status(hit_status), .hit_ovf(hit_ovf), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] m, en, ch, act, clr;
        logic         fl, rs, ak;
        logic         req;
        logic [W-1:0] id;
        logic         ea;
        logic [N-1:0] hit;
        logic         ovf, hlt;
    } vec_t;

    typedef struct {
        string        name;
        logic         chk_id;
        logic         req;
        logic [W-1:0] id;
        logic         ea;
        logic [N-1:0] hit;
        logic         ovf, hlt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, int m, int en, int ch, int act, int clr, int fl, int rs, int ak,
                                int req, int id, int ea, int hit, int ovf, int hlt);
        vec_t v;
        v.name = n;
        v.m = N'(m); v.en = N'(en); v.ch = N'(ch); v.act = N'(act); v.clr = N'(clr);
        v.fl = fl[0]; v.rs = rs[0]; v.ak = ak[0];
        v.req = req[0]; v.id = W'(id); v.ea = ea[0]; v.hit = N'(hit); v.ovf = ovf[0]; v.hlt = hlt[0];
        return v;
    endfunction

    task automatic push_exp(string n, logic chk_id, logic req, logic [W-1:0] id, logic ea,
                            logic [N-1:0] hit, logic ovf, logic hlt);
        exp_t e;
        e.name = n; e.chk_id = chk_id; e.req = req; e.id = id; e.ea = ea; e.hit = hit; e.ovf = ovf; e.hlt = hlt;
        sb.push_back(e);
    endtask

    // id/action are only defined while a request is up (and at reset), so they are masked otherwise
    task automatic check();
        exp_t e;
        logic [8:0] a, x, msk;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expected entry for this sample");
            return;
        end
        e   = sb.pop_front();
        a   = {bp_req, bp_id, bp_action, hit_status, hit_ovf, halted};
        x   = {e.req, e.id, e.ea, e.hit, e.ovf, e.hlt};
        msk = e.chk_id ? 9'h1FF : 9'b1_000_0_11_1_1;
        if ((a & msk) !== (x & msk)) begin
            n_bad++;
            $display("FAIL %s: got req=%b id=%0d act=%b hit=%b ovf=%b halted=%b, want req=%b id=%0d act=%b hit=%b ovf=%b halted=%b",
                     e.name, bp_req, bp_id, bp_action, hit_status, hit_ovf, halted,
                     e.req, e.id, e.ea, e.hit, e.ovf, e.hlt);
        end
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        match = v.m; cfg_en = v.en; cfg_chain = v.ch; cfg_action = v.act; hit_clr = v.clr;
        pipe_flush = v.fl; dbg_resume = v.rs; bp_ack = v.ak;
        push_exp(v.name, v.req, v.req, v.id, v.ea, v.hit, v.ovf, v.hlt);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic zero_inputs();
        match = '0; cfg_en = '0; cfg_chain = '0; cfg_action = '0; hit_clr = '0;
        pipe_flush = 1'b0; dbg_resume = 1'b0; bp_ack = 1'b0;
    endtask

    task automatic async_reset(string n);
        #2;
        zero_inputs();
        rst_n = 1'b0;
        #1;
        push_exp(n, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check();
        @(posedge clk);
        #1;
        push_exp({n, "_hold"}, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name            m  en ch act clr fl rs ak | req id ea hit ovf hlt
        tbl.push_back(mk("single_hit",   1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("single_ack",   0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("clr_all_0",    0, 3, 0, 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("prio_both",    3, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0));
        tbl.push_back(mk("ovf_in_req",   2, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 3, 1, 0));
        tbl.push_back(mk("prio_ack",     0, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3, 1, 0));
        tbl.push_back(mk("no_second",    0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 1, 0));
        tbl.push_back(mk("clr_bit0",     0, 3, 0, 0, 1, 0, 0, 0,  0, 0, 0, 2, 0, 0));
        tbl.push_back(mk("clr_bit1",     0, 3, 0, 0, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("hit_ch1",      2, 3, 0, 2, 0, 0, 0, 0,  1, 1, 1, 2, 0, 0));
        tbl.push_back(mk("req_hold_cfg", 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 2, 0, 0));
        tbl.push_back(mk("flush_alone",  0, 3, 0, 0, 0, 1, 0, 0,  0, 0, 0, 2, 0, 0));
        tbl.push_back(mk("clr_all_1",    0, 3, 0, 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("chain_lo",     1, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("chain_hi",     2, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("chain_both",   3, 3, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("chain_ack",    0, 3, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("clr_all_2",    0, 3, 0, 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("halt_req",     1, 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("halt_ack",     0, 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1));
        tbl.push_back(mk("halt_ovf",     1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1));
        tbl.push_back(mk("stray_ack",    0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1));
        tbl.push_back(mk("resume_hit",   1, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("after_resume", 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("clr_ovf",      0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("resume_idle",  0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("race_req",     1, 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("race_flush",   0, 1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("idle_flush",   1, 1, 0, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0, 0));
        tbl.push_back(mk("ack_flush",    0, 1, 0, 1, 0, 1, 0, 1,  0, 0, 0, 1, 0, 1));
        tbl.push_back(mk("race_resume",  0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("set_vs_clr",   1, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("svc_ack",      0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("clr_all_3",    0, 1, 0, 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ovf_req",      1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("ovf_set_clr",  1, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0));
        tbl.push_back(mk("ovf_ack",      0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk("ovf_clr",      0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("disabled",     3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

        zero_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset_state", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) drive(tbl[i]);

        drive(mk("arst_req",       1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        drive(mk("arst_req_ovf",   1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0));
        async_reset("arst_mid_req");
        drive(mk("post_rst_quiet", 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        drive(mk("post_rst_ack",   0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        drive(mk("post_rst_hit",   1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        drive(mk("post_rst_done",  0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        drive(mk("h2_req",         1, 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0));
        drive(mk("h2_ack",         0, 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1));
        async_reset("arst_mid_halt");
        drive(mk("post_halt_rst",  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
